// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: merges NCH like-SRAM request channels onto one shared
// like-SRAM memory port. Grants rotate round-robin. An ID FIFO records which
// channel owns each in-flight transaction so in-order responses can be routed
// back to their channel.
module cpu_mem_arbiter #(
  parameter int NCH   = 2,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int OUTST = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NCH-1:0]           ch_req,
  input  logic [NCH-1:0]           ch_wr,
  input  logic [2*NCH-1:0]         ch_size,
  input  logic [AW*NCH-1:0]        ch_addr,
  input  logic [DW*NCH-1:0]        ch_wdata,
  output logic [NCH-1:0]           ch_addr_ok,
  output logic [NCH-1:0]           ch_data_ok,
  output logic [DW-1:0]            ch_rdata,
  output logic                     mem_req,
  output logic                     mem_wr,
  output logic [1:0]               mem_size,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic                     mem_addr_ok,
  input  logic                     mem_data_ok,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(OUTST):0]   outst_cnt,
  output logic                     err_spurious
);

  localparam int PW  = $clog2(OUTST);
  localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [IDW-1:0] fifo_q [OUTST];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW:0]    cnt_q, cnt_d;
  logic [IDW-1:0] last_gnt_q;
  logic           err_q;

  logic [IDW-1:0] gnt;
  logic           full;
  logic           accept;
  logic           pop;

  // Round-robin grant: first requesting channel after the last accepted one.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt   = last_gnt_q;
    for (int k = 1; k <= NCH; k++) begin
      int idx;
      idx = (int'(last_gnt_q) + k) % NCH;
      if (!found && ch_req[idx]) begin
        found = 1'b1;
        gnt   = IDW'(idx);
      end
    end
  end

  // Handshake qualifiers; everything is gated by resetn so outputs read 0 in reset.
  always_comb begin
    full    = (cnt_q == (PW+1)'(OUTST));
    mem_req = resetn & (|ch_req) & ~full;
    accept  = mem_req & mem_addr_ok;
    pop     = resetn & mem_data_ok & (cnt_q != '0);
  end

  // Memory-side request mux from the granted channel, zeroed when idle.
  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (mem_req) begin
      mem_wr    = ch_wr[gnt];
      mem_size  = ch_size[int'(gnt)*2 +: 2];
      mem_addr  = ch_addr[int'(gnt)*AW +: AW];
      mem_wdata = ch_wdata[int'(gnt)*DW +: DW];
    end
  end

  // Channel-side handshakes: accept goes to the grantee, response to the FIFO head.
  always_comb begin
    ch_addr_ok = '0;
    ch_data_ok = '0;
    ch_rdata   = '0;
    if (accept) begin
      ch_addr_ok[gnt] = 1'b1;
    end
    if (pop) begin
      ch_data_ok[fifo_q[head_q]] = 1'b1;
      ch_rdata                   = mem_rdata;
    end
  end

  // Next-state for FIFO pointers and occupancy; push and pop may coincide.
  always_comb begin
    head_d = pop    ? head_q + 1'b1 : head_q;
    tail_d = accept ? tail_q + 1'b1 : tail_q;
    cnt_d  = cnt_q;
    if (accept && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !accept) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control state: pointers, occupancy, round-robin pointer and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      last_gnt_q <= IDW'(NCH-1);
      err_q      <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (accept) begin
        last_gnt_q <= gnt;
      end
      if (mem_data_ok && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // ID storage: only entries between head and tail are ever read, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[tail_q] <= gnt;
    end
  end

  assign outst_cnt    = cnt_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Testbench for cpu_mem_arbiter (NCH=2, OUTST=4): a hand-computed cycle table,
// directed multi-cycle sequences and a randomized run against a queue model.
module tb_cpu_mem_arbiter;

  localparam int NCH   = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int OUTST = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NCH-1:0]    ch_req, ch_wr;
  logic [2*NCH-1:0]  ch_size;
  logic [AW*NCH-1:0] ch_addr;
  logic [DW*NCH-1:0] ch_wdata;
  logic [NCH-1:0]    ch_addr_ok, ch_data_ok;
  logic [DW-1:0]     ch_rdata;
  logic              mem_req, mem_wr;
  logic [1:0]        mem_size;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok, mem_data_ok;
  logic [DW-1:0]     mem_rdata;
  logic [$clog2(OUTST):0] outst_cnt;
  logic              err_spurious;

  int total = 0;
  int bad   = 0;

  cpu_mem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .OUTST(OUTST)) dut (
    .clk(clk), .resetn(resetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
    .ch_wdata(ch_wdata), .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok),
    .ch_rdata(ch_rdata), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata), .outst_cnt(outst_cnt), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        aok;
    logic        dok;
    logic [31:0] rd;
    logic        e_mreq;
    logic [1:0]  e_aok;
    logic [1:0]  e_dok;
    logic [31:0] e_addr;
    logic [31:0] e_rd;
    int          e_cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic [1:0] wr,
                       input logic aok, input logic dok, input logic [31:0] rd);
    ch_req      = req;
    ch_wr       = wr;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(logic [1:0] req, logic aok, logic dok, logic [31:0] rd,
                              logic mreq, logic [1:0] eaok, logic [1:0] edok,
                              logic [31:0] eaddr, logic [31:0] erd, int ecnt);
    vec_t v;
    v.req = req; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_mreq = mreq; v.e_aok = eaok; v.e_dok = edok;
    v.e_addr = eaddr; v.e_rd = erd; v.e_cnt = ecnt;
    return v;
  endfunction

  // Round-robin reference: first requester after 'last', modulo NCH.
  function automatic int rr(int last, logic [1:0] req);
    for (int k = 1; k <= NCH; k++) begin
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    end
    return 0;
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    #1;
  endtask

  localparam logic [31:0] A0 = 32'hbfc00000;
  localparam logic [31:0] A1 = 32'h00001000;

  initial begin
    int q[$];
    int last;

    resetn = 1'b0;
    drive(2'b11, 2'b11, 1'b1, 1'b0, '0);
    ch_size  = 4'b0110;
    ch_addr  = {A1, A0};
    ch_wdata = {32'h11111111, 32'h22222222};
    #2;
    chk("rst_cnt", outst_cnt, 0);
    chk("rst_err", err_spurious, 0);
    chk("rst_mreq", mem_req, 0);
    chk("rst_aok", ch_addr_ok, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    next_cycle();
    resetn = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, '0);
    next_cycle();
    chk("post_rst_cnt", outst_cnt, 0);

    // Cycle table from reset: round-robin, full boundary, push+pop, hold of last_gnt.
    vecs[0]  = mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, A0, 32'h0,  1);
    vecs[1]  = mk(2'b11, 1, 0, 32'h0,  1, 2'b10, 2'b00, A1, 32'h0,  2);
    vecs[2]  = mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, A0, 32'h0,  3);
    vecs[3]  = mk(2'b11, 1, 0, 32'h0,  1, 2'b10, 2'b00, A1, 32'h0,  4);
    vecs[4]  = mk(2'b11, 1, 0, 32'h0,  0, 2'b00, 2'b00, 0,  32'h0,  4);
    vecs[5]  = mk(2'b11, 1, 1, 32'h11, 0, 2'b00, 2'b01, 0,  32'h11, 3);
    vecs[6]  = mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, A0, 32'h0,  4);
    vecs[7]  = mk(2'b11, 1, 1, 32'h22, 0, 2'b00, 2'b10, 0,  32'h22, 3);
    vecs[8]  = mk(2'b10, 1, 1, 32'h33, 1, 2'b10, 2'b01, A1, 32'h33, 3);
    vecs[9]  = mk(2'b00, 1, 1, 32'h44, 0, 2'b00, 2'b10, 0,  32'h44, 2);
    vecs[10] = mk(2'b01, 0, 0, 32'h0,  1, 2'b00, 2'b00, A0, 32'h0,  2);
    vecs[11] = mk(2'b11, 1, 0, 32'h0,  1, 2'b01, 2'b00, A0, 32'h0,  3);
    vecs[12] = mk(2'b00, 0, 1, 32'h55, 0, 2'b00, 2'b01, 0,  32'h55, 2);
    vecs[13] = mk(2'b00, 0, 1, 32'h66, 0, 2'b00, 2'b10, 0,  32'h66, 1);
    vecs[14] = mk(2'b00, 0, 1, 32'h77, 0, 2'b00, 2'b01, 0,  32'h77, 0);
    vecs[15] = mk(2'b00, 0, 0, 32'h0,  0, 2'b00, 2'b00, 0,  32'h0,  0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].req, 2'b00, vecs[i].aok, vecs[i].dok, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("tbl%0d_mreq", i), mem_req, vecs[i].e_mreq);
      chk($sformatf("tbl%0d_aok", i), ch_addr_ok, vecs[i].e_aok);
      chk($sformatf("tbl%0d_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("tbl%0d_dok", i), ch_data_ok, vecs[i].e_dok);
      chk($sformatf("tbl%0d_rdata", i), ch_rdata, vecs[i].e_rd);
      next_cycle();
      chk($sformatf("tbl%0d_cnt", i), outst_cnt, vecs[i].e_cnt);
    end
    chk("tbl_err", err_spurious, 0);

    // Ordering across channels: ch1 then ch0, responses routed in acceptance order.
    do_reset();
    drive(2'b10, 2'b00, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("ord_aok1", ch_addr_ok, 2'b10);
    chk("ord_addr1", mem_addr, A1);
    next_cycle();
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("ord_aok0", ch_addr_ok, 2'b01);
    chk("ord_addr0", mem_addr, A0);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hAAAA);
    @(negedge clk);
    chk("ord_dok_first", ch_data_ok, 2'b10);
    chk("ord_rd_first", ch_rdata, 32'hAAAA);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h5555);
    @(negedge clk);
    chk("ord_dok_second", ch_data_ok, 2'b01);
    chk("ord_rd_second", ch_rdata, 32'h5555);
    next_cycle();
    chk("ord_cnt", outst_cnt, 0);

    // Write pass-through on channel 1.
    ch_size  = 4'b0010;
    ch_addr  = {32'h00000003, A0};
    ch_wdata = {32'h000000EE, 32'h12345678};
    drive(2'b10, 2'b10, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("wr_mreq", mem_req, 1);
    chk("wr_mwr", mem_wr, 1);
    chk("wr_size", mem_size, 0);
    chk("wr_addr", mem_addr, 32'h3);
    chk("wr_wdata", mem_wdata, 32'hEE);
    chk("wr_aok", ch_addr_ok, 2'b10);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hDEAD);
    @(negedge clk);
    chk("wr_dok", ch_data_ok, 2'b10);
    next_cycle();
    ch_size = 4'b0110;
    ch_addr = {A1, A0};

    // Simultaneous push and pop at outst_cnt=2.
    drive(2'b01, 2'b00, 1'b1, 1'b0, '0);
    next_cycle();
    drive(2'b10, 2'b00, 1'b1, 1'b0, '0);
    next_cycle();
    chk("pp_pre_cnt", outst_cnt, 2);
    drive(2'b01, 2'b00, 1'b1, 1'b1, 32'h0101);
    @(negedge clk);
    chk("pp_aok", ch_addr_ok, 2'b01);
    chk("pp_dok_oldest", ch_data_ok, 2'b01);
    next_cycle();
    chk("pp_cnt", outst_cnt, 2);
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h0202);
    @(negedge clk);
    chk("pp_dok2", ch_data_ok, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("pp_dok3", ch_data_ok, 2'b01);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0, '0);
    chk("pp_drained", outst_cnt, 0);

    // Reset mid-flight with 3 reads outstanding, then a stray response.
    drive(2'b11, 2'b00, 1'b1, 1'b0, '0);
    repeat (3) next_cycle();
    chk("mf_cnt3", outst_cnt, 3);
    resetn = 1'b0;
    #1;
    chk("mf_cnt0", outst_cnt, 0);
    chk("mf_mreq", mem_req, 0);
    chk("mf_aok", ch_addr_ok, 0);
    chk("mf_addr", mem_addr, 0);
    next_cycle();
    resetn = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hBEEF);
    @(negedge clk);
    chk("mf_no_dok", ch_data_ok, 0);
    chk("mf_no_rd", ch_rdata, 0);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0, '0);
    chk("mf_err", err_spurious, 1);
    next_cycle();
    chk("mf_err_sticky", err_spurious, 1);

    // Randomized run against a queue-of-owners model.
    do_reset();
    chk("rnd_err_clear", err_spurious, 0);
    last = NCH - 1;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic [1:0] req, wr;
      logic       aok, dok, emreq, acc, epop;
      logic [31:0] rd;
      logic [1:0] e_aok, e_dok;
      logic [31:0] e_addr, e_wdata, e_rd;
      logic [1:0] e_size;
      logic       e_wr;
      int g;
      req = 2'($urandom);
      wr  = 2'($urandom);
      aok = 1'($urandom);
      dok = (q.size() > 0) ? 1'($urandom) : 1'b0;
      rd  = $urandom;
      ch_size  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
      ch_addr  = {$urandom, $urandom};
      ch_wdata = {$urandom, $urandom};
      drive(req, wr, aok, dok, rd);

      emreq  = (req != 0) && (q.size() < OUTST);
      g      = rr(last, req);
      acc    = emreq && aok;
      epop   = dok && (q.size() > 0);
      e_wr    = emreq ? wr[g] : 1'b0;
      e_size  = emreq ? ch_size[g*2 +: 2] : 2'd0;
      e_addr  = emreq ? ch_addr[g*32 +: 32] : 32'h0;
      e_wdata = emreq ? ch_wdata[g*32 +: 32] : 32'h0;
      e_aok   = acc ? 2'(1 << g) : 2'b00;
      e_dok   = epop ? 2'(1 << q[0]) : 2'b00;
      e_rd    = epop ? rd : 32'h0;

      @(negedge clk);
      chk("rnd_mreq", mem_req, emreq);
      chk("rnd_mwr", mem_wr, e_wr);
      chk("rnd_size", mem_size, e_size);
      chk("rnd_addr", mem_addr, e_addr);
      chk("rnd_wdata", mem_wdata, e_wdata);
      chk("rnd_aok", ch_addr_ok, e_aok);
      chk("rnd_dok", ch_data_ok, e_dok);
      chk("rnd_rdata", ch_rdata, e_rd);
      next_cycle();
      if (epop) void'(q.pop_front());
      if (acc) begin
        q.push_back(g);
        last = g;
      end
      chk("rnd_cnt", outst_cnt, q.size());
    end
    chk("rnd_err_end", err_spurious, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Parametrised N-channel arbiter merging the CPU's like-SRAM request channels (inst fetch, data, and later more masters) onto one shared like-SRAM memory port.
- Replaces the split inst/data SRAM ports of the current top level and is the first step toward an AXI bridge.
- Supports multiple outstanding transactions per port, round-robin arbitration, and in-order response routing through an ID FIFO.

Parameters:
- NCH, 2, number of requesting channels (1..8); channel 0 = inst, channel 1 = data.
- AW, 32, address width.
- DW, 32, data width.
- OUTST, 4, maximum accepted-but-unanswered transactions (power of two, 2..16).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- ch_req  in  NCH  per-channel request valid.
- ch_wr  in  NCH  per-channel write (1) / read (0).
- ch_size  in  2*NCH  per-channel size, 0=byte, 1=half, 2=word; channel i at [2i+1:2i].
- ch_addr  in  AW*NCH  per-channel address, packed the same way.
- ch_wdata  in  DW*NCH  per-channel write data.
- ch_addr_ok  out  NCH  request accepted this cycle.
- ch_data_ok  out  NCH  response for that channel's oldest request.
- ch_rdata  out  DW  shared read data, valid for the channel whose ch_data_ok is high.
- mem_req  out  1  memory-side request.
- mem_wr  out  1  memory-side write / read.
- mem_size  out  2  memory-side size.
- mem_addr  out  AW  memory-side address.
- mem_wdata  out  DW  memory-side write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory returns a response.
- mem_rdata  in  DW  memory read data.
- outst_cnt  out  $clog2(OUTST)+1  number of in-flight transactions.
- err_spurious  out  1  sticky flag: mem_data_ok seen with no transaction in flight.

Behaviour:
- Reset (async, resetn=0):
  - ID FIFO empty; outst_cnt=0; err_spurious=0.
  - Round-robin pointer last_gnt=NCH-1, so channel 0 has priority on the first grant.
  - All outputs are 0 while reset is asserted.
  - Any in-flight transactions are dropped; responses arriving after reset release set err_spurious.
- Arbitration (combinational within the cycle):
  - Grant g = first index with ch_req set, scanning from last_gnt+1 with wrap-around modulo NCH.
  - full = (outst_cnt==OUTST).
  - mem_req = |ch_req & ~full.
  - mem_wr, mem_size, mem_addr and mem_wdata are muxed from channel g; they are 0 when mem_req=0.
- Acceptance:
  - accept = mem_req & mem_addr_ok.
  - ch_addr_ok[g] = accept; all other ch_addr_ok bits are 0. Zero-cycle pass-through.
  - On the accepting edge, push g into the ID FIFO and set last_gnt<=g.
  - last_gnt is unchanged when there is no acceptance. A channel that is not accepted must hold its request, per like-SRAM rules.
- Response:
  - On mem_data_ok with the FIFO non-empty: ch_data_ok[head]=1 in the same cycle, ch_rdata=mem_rdata, and the head is popped at the edge.
  - Writes also receive data_ok; ch_rdata is don't-care for writes.
  - ch_rdata=0 when no data_ok is asserted.
  - mem_data_ok with the FIFO empty: no ch_data_ok asserted, err_spurious<=1 (cleared only by reset).
- Ordering: responses are strictly in acceptance order across all channels; the memory port returns in order.
- Simultaneous push and pop in the same cycle:
  - outst_cnt is unchanged; head and tail pointers both advance.
  - Allowed when not full.
  - When full, push is blocked combinationally even if a pop occurs in the same cycle (no bypass). Next cycle, full=0.
- Same-cycle response: an accepted request may receive mem_data_ok in the same cycle only if the FIFO was non-empty; that response belongs to the old head. A zero-latency response to the new request is not supported.
- Counters and pointers:
  - FIFO pointers are $clog2(OUTST) bits and wrap naturally.
  - outst_cnt never exceeds OUTST.
- Degenerate case NCH=1: the arbiter reduces to a pass-through with outstanding tracking.

Test Plan:
- Reset mid-flight: 3 reads accepted, resetn pulsed low → outst_cnt=0 immediately, all outputs 0; a later mem_data_ok → err_spurious=1, no ch_data_ok.
- Round-robin: ch_req=2'b11 held, mem_addr_ok=1 every cycle, OUTST=4 → grants 0,1,0,1; ch_addr_ok toggles; the 5th request is blocked (mem_req=0) until the first data_ok.
- Full boundary: 4 accepted with no data_ok → outst_cnt=4, mem_req=0. Same cycle as data_ok: still blocked. Next cycle: accept resumes, outst_cnt returns to 4.
- Ordering: ch1 read to 0x1000 accepted, then ch0 read to 0xbfc00000; memory returns 0xAAAA then 0x5555 → ch_data_ok[1] with 0xAAAA, then ch_data_ok[0] with 0x5555.
- Simultaneous push/pop at outst_cnt=2: accept plus data_ok in one cycle → outst_cnt stays 2; the popped ID is the older one.
- Write passthrough: ch1 wr=1, size=0, addr 0x3, wdata 0x000000EE → mem_* mirror these exactly; ch_data_ok[1] is returned on the response.
